ysyx_ifu_rsp: RTL

YSYX_IFU_RSP -- requirements
Module: ysyx_ifu_rsp

---
 rtl/ysyx_ifu_rsp_pkg.sv | 18 +
 rtl/ysyx_ifu_rsp_if.sv | 24 ++
 rtl/ysyx_ifu_rsp_sram.sv | 25 ++
 rtl/ysyx_ifu_rsp.sv | 114 +++++++++++
 4 files changed

// File: rtl/ysyx_ifu_rsp_pkg.sv
// Shared types and constants for the instruction fetch responder.
package ysyx_ifu_rsp_pkg;

    // Fetch responder FSM encoding
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Response codes carried on rresp
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecerr = 2'b11;

    // Wait counter width; holds LATENCY-2 for LATENCY up to 15
    localparam int unsigned CntW = 4;

endpackage

// File: rtl/ysyx_ifu_rsp_if.sv
// Fetch request/response channel between the fetch unit and the responder.
interface ysyx_ifu_rsp_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [1:0]        rresp;

    // Fetch unit side
    modport master (
        output araddr, arvalid,
        input  arready, rdata, rvalid, rresp
    );

    // Responder side
    modport slave (
        input  araddr, arvalid,
        output arready, rdata, rvalid, rresp
    );
endinterface

// File: rtl/ysyx_ifu_rsp_sram.sv
// Backing store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a preload survives reset.
module ysyx_ifu_rsp_sram #(
    parameter int unsigned DEPTH_W = 10,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_W];

    // Read returns the pre-write contents when read and write hit the same word
    assign rdata = mem[raddr];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/ysyx_ifu_rsp.sv
// Instruction fetch responder: accepts one fetch at a time, answers after a
// fixed LATENCY (1..15) with the word read from the backing store at accept.
module ysyx_ifu_rsp
    import ysyx_ifu_rsp_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       DEPTH_W = 10,
    parameter int unsigned       LATENCY = 2,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_ifu_rsp_if.slave      bus,
    input  logic               ld_we,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]  ld_data
);
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [1:0]        pend_resp_q, pend_resp_d;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              accept;

    logic [ADDR_W-1:0]  offset;
    logic               in_range;
    logic [DEPTH_W-1:0] rd_idx;
    logic [DATA_W-1:0]  rd_word;

    // Range check is done on the full offset before it is truncated to an index
    assign offset   = bus.araddr - BASE;
    assign in_range = (bus.araddr >= BASE) && ((offset >> (DEPTH_W + 2)) == '0) &&
                      (bus.araddr[1:0] == 2'b00);
    assign rd_idx   = offset[DEPTH_W+1:2];

    ysyx_ifu_rsp_sram #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_sram (
        .clk   (clk),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    // Next-state logic: IDLE accepts, WAIT counts down, RESP strobes one cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.arvalid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(LATENCY - 2);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture the response at accept so later address or store changes are ignored
    always_comb begin
        pend_data_d = pend_data_q;
        pend_resp_d = pend_resp_q;
        if (accept) begin
            pend_data_d = in_range ? rd_word : '0;
            pend_resp_d = in_range ? RespOkay : RespDecerr;
        end
    end

    // State, counter and output registers; outputs only change on entry to RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pend_data_q <= '0;
            pend_resp_q <= RespOkay;
            rdata_q     <= '0;
            rresp_q     <= RespOkay;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_data_q <= pend_data_d;
            pend_resp_q <= pend_resp_d;
            if (state_d == StResp) begin
                rdata_q <= pend_data_d;
                rresp_q <= pend_resp_d;
            end
        end
    end

    assign bus.arready = (state_q == StIdle);
    assign bus.rvalid  = (state_q == StResp);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
endmodule
